// File: rtl/button_defs.sv
`default_nettype none
// ============================================================================
//  Module   : button_defs (package)
//  Brief    : Shared state encodings and default timing for button conditioning
//  Revision : 1.0 - initial release
// ============================================================================
package button_defs;

  // Per-channel press FSM states; encodings are fixed so firmware/debug
  // probes can decode the 3-bit state directly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_HELD   = 3'd2,
    ST_REPEAT = 3'd3,
    ST_DISARM = 3'd4
  } btn_state_e;

  // Default timing at 100 MHz: 10 ms debounce, 0.5 s hold, 0.1 s repeat.
  localparam int DEF_N_BTN         = 5;
  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // Largest of three timing values; sizes the shared per-channel counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module   : button_channel
//  Brief    : One button: 2-FF synchroniser, debounce/hold/repeat FSM and
//             registered level / press / repeat outputs
//  Revision : 1.0 - initial release
// ============================================================================
module button_channel
  import button_defs::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES))
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic mcen
);

  // Terminal counts; each fits because CNT_W covers the largest period.
  localparam logic [CNT_W-1:0] DB_TC     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  logic             s1_q, s2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;   // accepted-press event, aligned with state
  logic             pulse_q, pulse_d;   // press or repeat event, aligned with state
  logic             dpb_q, scen_q, mcen_q;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pb;
      s2_q <= s1_q;
    end
  end

  // FSM state, counter and event flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic; the counter is cleared on every transition and every
  // terminal count, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    press_d = 1'b0;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s2_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!s2_q) begin
          state_d = ST_DISARM;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TC) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!s2_q) begin
          state_d = ST_DISARM;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_TC) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      ST_DISARM: begin
        // A release glitch returns to HELD silently and restarts the hold timer.
        if (s2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register stage: level decoded from the state register, pulses
  // taken from the event flags, so all three outputs move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpb_q  <= 1'b0;
      scen_q <= 1'b0;
      mcen_q <= 1'b0;
    end else begin
      dpb_q  <= (state_q == ST_HELD) || (state_q == ST_REPEAT) || (state_q == ST_DISARM);
      scen_q <= press_q;
      mcen_q <= pulse_q;
    end
  end

  assign dpb  = dpb_q;
  assign scen = scen_q;
  assign mcen = mcen_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Brief    : N_BTN independent button channels (debounce, press, auto-repeat)
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_defs::*;
#(
  parameter int N_BTN         = DEF_N_BTN,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pb,
  output logic [N_BTN-1:0] dpb,
  output logic [N_BTN-1:0] scen,
  output logic [N_BTN-1:0] mcen
);

  // One fully independent channel per button bit.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .pb  (pb[i]),
      .dpb (dpb[i]),
      .scen(scen[i]),
      .mcen(mcen[i])
    );
  end

endmodule
`default_nettype wire
